// File: rtl/rr_resource_arbiter.sv
// rr_resource_arbiter
// Round-robin arbiter that shares one resource between N requesters. A grant
// is held exclusively until the owner pulses done, drops its request, or the
// hold limit expires (forced release with a one-cycle timeout pulse). Every
// release is followed by at least one bubble cycle before the next grant.
//
// Parameters:
//   N        number of requesters (2..8)
//   MAX_HOLD maximum cycles a grant may be held (>= 2)
//   IDW      width of gnt_id, derived as $clog2(N)
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   req       per-requester level request
//   done      per-requester release pulse (only the owner's bit is honoured)
//   gnt       one-hot grant, registered
//   gnt_valid OR of gnt, registered
//   gnt_id    index of the current owner, 0 when idle
//   timeout   one-cycle pulse in the cycle a grant is force-released
//
// Optional build macro RR_ARB_SVA_EN compiles in embedded concurrent
// assertions and a cover property; behaviour is identical without it.
module rr_resource_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   done,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic           timeout
);

  localparam int HW = $clog2(MAX_HOLD);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [IDW-1:0]   ptr_r;
  logic [IDW-1:0]   ptr_s;
  logic [HW-1:0]    hold_r;
  logic [HW-1:0]    hold_s;
  logic [N-1:0]     gnt_r;
  logic [N-1:0]     gnt_s;
  logic             gnt_valid_r;
  logic             gnt_valid_s;
  logic [IDW-1:0]   gnt_id_r;
  logic [IDW-1:0]   gnt_id_s;
  logic             timeout_r;
  logic             timeout_s;

  logic [IDW:0]     pick_s;
  logic             pick_found_s;
  logic [IDW-1:0]   pick_id_s;
  logic             rel_done_s;
  logic             rel_abort_s;
  logic             rel_limit_s;
  logic [IDW-1:0]   ptr_after_s;

  // Round-robin search: first set request at or above the pointer, wrapping.
  // Returns {found, index}. Scanning downward lets the lowest offset win.
  function automatic logic [IDW:0] rr_pick(input logic [N-1:0] r,
                                           input logic [IDW-1:0] p);
    logic           found;
    logic [IDW-1:0] id;
    int             idx;
    found = 1'b0;
    id    = {IDW{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % N;
      if (r[idx]) begin
        found = 1'b1;
        id    = IDW'(idx);
      end
    end
    return {found, id};
  endfunction

  // Candidate owner for the next grant and release-condition decode.
  always_comb begin
    pick_s       = rr_pick(req, ptr_r);
    pick_found_s = pick_s[IDW];
    pick_id_s    = pick_s[IDW-1:0];
    rel_done_s   = done[gnt_id_r];
    rel_abort_s  = ~req[gnt_id_r];
    rel_limit_s  = (hold_r == HW'(MAX_HOLD - 1));
    ptr_after_s  = (gnt_id_r == IDW'(N - 1)) ? {IDW{1'b0}} : (gnt_id_r + IDW'(1));
  end

  // Next-state and next-output logic for the IDLE/GRANT machine.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    hold_s      = hold_r;
    gnt_s       = gnt_r;
    gnt_valid_s = gnt_valid_r;
    gnt_id_s    = gnt_id_r;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_found_s) begin
          state_s     = GRANT;
          hold_s      = {HW{1'b0}};
          gnt_s       = {{(N-1){1'b0}}, 1'b1} << pick_id_s;
          gnt_valid_s = 1'b1;
          gnt_id_s    = pick_id_s;
        end else begin
          gnt_s       = {N{1'b0}};
          gnt_valid_s = 1'b0;
          gnt_id_s    = {IDW{1'b0}};
        end
      end
      GRANT: begin
        if (rel_done_s || rel_abort_s || rel_limit_s) begin
          state_s     = IDLE;
          ptr_s       = ptr_after_s;
          hold_s      = {HW{1'b0}};
          gnt_s       = {N{1'b0}};
          gnt_valid_s = 1'b0;
          gnt_id_s    = {IDW{1'b0}};
          // Only a pure hold-limit expiry counts as a timeout.
          timeout_s   = ~rel_done_s & ~rel_abort_s;
        end else begin
          hold_s      = hold_r + HW'(1);
        end
      end
      default: begin
        state_s     = IDLE;
        ptr_s       = {IDW{1'b0}};
        hold_s      = {HW{1'b0}};
        gnt_s       = {N{1'b0}};
        gnt_valid_s = 1'b0;
        gnt_id_s    = {IDW{1'b0}};
      end
    endcase
  end

  // State, pointer, hold counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= {IDW{1'b0}};
      hold_r      <= {HW{1'b0}};
      gnt_r       <= {N{1'b0}};
      gnt_valid_r <= 1'b0;
      gnt_id_r    <= {IDW{1'b0}};
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      hold_r      <= hold_s;
      gnt_r       <= gnt_s;
      gnt_valid_r <= gnt_valid_s;
      gnt_id_r    <= gnt_id_s;
      timeout_r   <= timeout_s;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_valid = gnt_valid_r;
  assign gnt_id    = gnt_id_r;
  assign timeout   = timeout_r;

`ifdef RR_ARB_SVA_EN
  // Grant is one-hot or zero.
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt))
    else $error("%0t arbiter onehot violation gnt_id=%0d", $time, gnt_id);

  // Valid flag mirrors the grant vector.
  a_valid: assert property (@(posedge clk) disable iff (!rst_n)
    gnt_valid == (|gnt))
    else $error("%0t arbiter gnt_valid mismatch gnt_id=%0d", $time, gnt_id);

  // A grant bit may only rise for a requester that was requesting.
  a_req_before_gnt: assert property (@(posedge clk) disable iff (!rst_n)
    ((gnt & ~$past(gnt) & ~$past(req)) == {N{1'b0}}))
    else $error("%0t arbiter grant without request gnt_id=%0d", $time, gnt_id);

  // Timeout marks the falling edge of a grant.
  a_timeout_edge: assert property (@(posedge clk) disable iff (!rst_n)
    timeout |-> ($past(gnt_valid) && !gnt_valid))
    else $error("%0t arbiter timeout without release gnt_id=%0d", $time, gnt_id);

  // No grant outlives the hold limit.
  a_max_hold: assert property (@(posedge clk) disable iff (!rst_n)
    $rose(gnt_valid) |-> ##[1:MAX_HOLD] !gnt_valid)
    else $error("%0t arbiter hold limit exceeded gnt_id=%0d", $time, gnt_id);

  // Back-to-back grants separated by a single bubble.
  c_b2b: cover property (@(posedge clk) disable iff (!rst_n)
    gnt_valid ##1 !gnt_valid ##1 gnt_valid);
`endif

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Directed self-checking bench for rr_resource_arbiter (N=4, MAX_HOLD=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rr_resource_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       timeout;

  int n_chk;
  int n_fail;

  rr_resource_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_grant(input string tag, input logic [3:0] eg, input logic ev,
                             input logic [1:0] eid, input logic eto);
    check({tag, ".gnt"}, {28'd0, gnt}, {28'd0, eg});
    check({tag, ".gnt_valid"}, {31'd0, gnt_valid}, {31'd0, ev});
    check({tag, ".gnt_id"}, {30'd0, gnt_id}, {30'd0, eid});
    check({tag, ".timeout"}, {31'd0, timeout}, {31'd0, eto});
  endtask

  initial begin
    logic [1:0] order [5];
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    req    = 4'b0000;
    done   = 4'b0000;
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;

    // Reset values
    tick();
    tick();
    check_grant("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;

    // Idle with no requests
    for (int i = 0; i < 10; i++) begin
      tick();
      check_grant("idle", 4'b0000, 1'b0, 2'd0, 1'b0);
    end

    // Single requester 2, released by done after three granted samples
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_grant("single2", 4'b0100, 1'b1, 2'd2, 1'b0);
    end
    done = 4'b0100;
    tick();
    check_grant("single2_rel", 4'b0000, 1'b0, 2'd0, 1'b0);
    done = 4'b0000;
    req  = 4'b0000;
    tick();

    // Pointer now 3: with requesters 0 and 3 pending, 3 wins
    req = 4'b1001;
    tick();
    check_grant("ptr3", 4'b1000, 1'b1, 2'd3, 1'b0);
    // Abort release by dropping req[3]; no timeout
    req = 4'b0000;
    tick();
    check_grant("abort3", 4'b0000, 1'b0, 2'd0, 1'b0);

    // Fairness: all request, each owner pulses done two cycles after grant
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      check_grant("rr_grant", 4'b0001 << order[g], 1'b1, order[g], 1'b0);
      tick();
      check_grant("rr_hold", 4'b0001 << order[g], 1'b1, order[g], 1'b0);
      done = 4'b0001 << order[g];
      tick();
      check_grant("rr_bubble", 4'b0000, 1'b0, 2'd0, 1'b0);
      done = 4'b0000;
      if (g == 4) req = 4'b0000;
    end
    tick();
    check_grant("rr_quiet", 4'b0000, 1'b0, 2'd0, 1'b0);

    // Timeout: requester 1 holds, never done; non-owner done is ignored
    req = 4'b0010;
    tick();
    check_grant("to_grant", 4'b0010, 1'b1, 2'd1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      done = (i == 2) ? 4'b0001 : 4'b0000;
      tick();
      check_grant("to_hold", 4'b0010, 1'b1, 2'd1, 1'b0);
    end
    done = 4'b0000;
    tick();
    check_grant("to_fire", 4'b0000, 1'b0, 2'd0, 1'b1);
    tick();
    check_grant("to_regrant", 4'b0010, 1'b1, 2'd1, 1'b0);

    // done coinciding with the hold limit: normal release, no timeout
    for (int i = 0; i < 7; i++) begin
      tick();
      check_grant("dl_hold", 4'b0010, 1'b1, 2'd1, 1'b0);
    end
    done = 4'b0010;
    tick();
    check_grant("dl_release", 4'b0000, 1'b0, 2'd0, 1'b0);
    done = 4'b0000;
    tick();
    check_grant("dl_regrant", 4'b0010, 1'b1, 2'd1, 1'b0);

    // Asynchronous reset mid-grant, between edges
    tick();
    check_grant("pre_rst", 4'b0010, 1'b1, 2'd1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_grant("async_rst", 4'b0000, 1'b0, 2'd0, 1'b0);
    req = 4'b1010;
    tick();
    check_grant("rst_hold", 4'b0000, 1'b0, 2'd0, 1'b0);
    #3;
    rst_n = 1'b1;
    // Pointer restarted at 0, so requester 1 wins over 3
    tick();
    check_grant("post_rst", 4'b0010, 1'b1, 2'd1, 1'b0);
    req = 4'b1000;
    tick();
    check_grant("post_abort", 4'b0000, 1'b0, 2'd0, 1'b0);
    tick();
    check_grant("grant3", 4'b1000, 1'b1, 2'd3, 1'b0);
    done = 4'b1000;
    tick();
    check_grant("grant3_rel", 4'b0000, 1'b0, 2'd0, 1'b0);
    done = 4'b0000;
    req  = 4'b0000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_resource_arbiter.md
Name: rr_resource_arbiter

Overview:
- Round-robin arbiter that shares one resource (bus/datapath slot) between N requesters.
- Grants exclusive ownership to one requester at a time and holds the grant until the owner releases it or a hold-limit timeout fires.
- Sits between requester agents and the shared resource. It is the sequencing block for the resource, and it is the primary target of the team's concurrent-assertion checks.

Parameters:
- N, 4, number of requesters (2..8).
- MAX_HOLD, 8, maximum cycles a grant may be held before forced release (>=2).
- IDW, $clog2(N), width of gnt_id (derived, not overridden).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  per-requester request, level; held high until granted and used.
- done  in  N  per-requester release pulse; only done[gnt_id] is honoured while granted.
- gnt  out  N  one-hot grant, registered.
- gnt_valid  out  1  OR of gnt, registered.
- gnt_id  out  IDW  index of current owner; 0 when gnt_valid=0.
- timeout  out  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset is asynchronous and active-low on rst_n; clk is the only clock. On reset: gnt=0, gnt_valid=0, gnt_id=0, timeout=0, state=IDLE, priority pointer=0, hold counter=0. Mid-grant reset clears gnt immediately (asynchronously) with no timeout pulse.
- State machine has two states, IDLE and GRANT.
- IDLE:
  - If req!=0 at edge t, pick the first set req bit scanning from the pointer upward, with wrap-around.
  - gnt/gnt_valid/gnt_id are valid after edge t (latency 1 cycle). Go to GRANT and clear the hold counter.
  - If req==0, stay in IDLE.
- GRANT: the hold counter increments every cycle. Release conditions are evaluated in this priority order:
  1. done[gnt_id]=1: normal release.
  2. req[gnt_id]=0: abort release. No timeout pulse.
  3. Hold counter == MAX_HOLD-1: forced release. timeout=1 for exactly the cycle gnt drops.
- On any release:
  - gnt drops at the next edge and the state returns to IDLE.
  - The pointer becomes (gnt_id+1) mod N, so the released owner gets lowest priority.
  - At least one bubble cycle with gnt_valid=0 always separates consecutive grants.
- done bits of non-owners are ignored. done while in IDLE is ignored.
- done and timeout condition in the same cycle: done wins and timeout stays 0.
- gnt is always one-hot or zero. gnt_id changes only while gnt_valid=0 or on a grant edge.
- Fairness: with all req held high, grants go 0,1,2,...,N-1,0, each separated by one bubble. No requester waits more than N grants.
- Hold counter width is $clog2(MAX_HOLD). It never wraps, because the forced release occurs at MAX_HOLD-1.

Optional Feature:
- Macro: RR_ARB_SVA_EN.
- When defined, the following embedded concurrent assertions (clocked @(posedge clk), disabled iff !rst_n) are compiled in:
  - gnt is $onehot0.
  - gnt_valid == |gnt.
  - A gnt bit rises only if the matching req was high on the previous cycle.
  - timeout implies gnt_valid was high the previous cycle and is low now.
  - At most MAX_HOLD consecutive cycles of the same gnt.
  - A cover property for back-to-back grants with one bubble.
- Failures report $time and gnt_id via $error.
- When undefined: no assertion code and identical RTL behaviour.

Test Plan:
- Reset then req=4'b0000 for 10 cycles -> gnt=0, gnt_valid=0, timeout=0 throughout.
- req=4'b0100 at edge 3, done[2] pulsed at edge 6 -> gnt=4'b0100 at edges 4..6, gnt_id=2, gnt=0 at edge 7, pointer=3.
- req=4'b1111 held, each owner pulses done two cycles after its grant -> grant order 0,1,2,3,0, each grant separated by exactly one gnt_valid=0 cycle.
- req=4'b0010 held, never done, MAX_HOLD=8 -> gnt=4'b0010 for 8 cycles, timeout=1 in the cycle gnt drops, re-grant to 1 after one bubble (only requester).
- Owner 1 pulses done in the same cycle its counter hits MAX_HOLD-1 -> normal release, timeout stays 0.
- rst_n driven low mid-grant, between clock edges -> gnt/gnt_valid go 0 immediately, no timeout; after release, req=4'b1000 grants 3 with pointer restarted at 0.
